// File: rtl/mar_ram_unit.sv
// ============================================================================
// Module      : mar_ram_unit
// Description : Memory stage holding the MAR, the MDR and a small program/data
//               RAM, plus a byte-stream loader that fills the RAM from
//               address 0 while the CPU is held.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mar_ram_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_addr_load_n,
    input  logic              mdr_load_n,
    input  logic              ram_en_n,
    input  logic              ram_load_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        PROG_IDLE = 2'd1,
        PROG_FULL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic              prog_we;
    logic              cpu_we;

    logic [DATA_W-1:0] mem [DEPTH];

    // Loader FSM: next state, next loader address and loader write strobe.
    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        prog_we     = 1'b0;
        case (state_q)
            RUN: begin
                if (prog_mode) begin
                    state_d     = PROG_IDLE;
                    prog_addr_d = '0;
                end
            end
            PROG_IDLE: begin
                // Leaving program mode wins over a byte offered in the same cycle.
                if (!prog_mode) begin
                    state_d     = RUN;
                    prog_addr_d = '0;
                end else if (prog_valid) begin
                    prog_we     = 1'b1;
                    prog_addr_d = prog_addr_q + 1'b1;
                    if (prog_addr_q == {ADDR_W{1'b1}}) begin
                        state_d = PROG_FULL;
                    end
                end
            end
            PROG_FULL: begin
                if (!prog_mode) begin
                    state_d     = RUN;
                    prog_addr_d = '0;
                end
            end
            default: begin
                state_d     = RUN;
                prog_addr_d = '0;
            end
        endcase
    end

    // CPU writes only count while the CPU owns the RAM.
    assign cpu_we = (state_q == RUN) && !ram_load_n;

    // FSM state and loader address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            prog_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            prog_addr_q <= prog_addr_d;
        end
    end

    // MAR/MDR capture from the bus; frozen while the loader owns the RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else if (state_q == RUN) begin
            if (!mar_addr_load_n) begin
                mar_q <= bus_in[ADDR_W-1:0];
            end
            if (!mdr_load_n) begin
                mdr_q <= bus_in;
            end
        end
    end

    // RAM write port; contents survive reset but no write happens during it.
    // CPU writes use the pre-edge MAR/MDR, so same-cycle loads see old values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (prog_we) begin
                mem[prog_addr_q] <= prog_data;
            end else if (cpu_we) begin
                mem[mar_q] <= mdr_q;
            end
        end
    end

    // Combinational read path and status outputs decoded from the state register.
    always_comb begin
        bus_oe     = (state_q == RUN) && !ram_en_n;
        bus_out    = bus_oe ? mem[mar_q] : '0;
        prog_ready = (state_q == PROG_IDLE);
        prog_done  = (state_q == PROG_FULL);
        cpu_hold   = (state_q != RUN);
    end

endmodule

`default_nettype wire

// File: tb/tb_mar_ram_unit.sv
// ============================================================================
// Module      : tb_mar_ram_unit
// Description : Scoreboard bench for mar_ram_unit. Stimulus queues expected
//               status values (stamped with a cycle) and expected read words;
//               an independent monitor compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mar_ram_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       mar_addr_load_n;
    logic       mdr_load_n;
    logic       ram_en_n;
    logic       ram_load_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic       prog_done;
    logic       cpu_hold;
    logic [3:0] mar_q;
    logic [7:0] mdr_q;

    mar_ram_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_in          (bus_in),
        .mar_addr_load_n (mar_addr_load_n),
        .mdr_load_n      (mdr_load_n),
        .ram_en_n        (ram_en_n),
        .ram_load_n      (ram_load_n),
        .bus_out         (bus_out),
        .bus_oe          (bus_oe),
        .prog_mode       (prog_mode),
        .prog_valid      (prog_valid),
        .prog_data       (prog_data),
        .prog_ready      (prog_ready),
        .prog_done       (prog_done),
        .cpu_hold        (cpu_hold),
        .mar_q           (mar_q),
        .mdr_q           (mdr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signal selectors for status expectations.
    localparam int S_MAR = 0, S_MDR = 1, S_OE = 2, S_RDY = 3, S_DONE = 4, S_HOLD = 5;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] rdq[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [7:0] sig_val(int s);
        case (s)
            S_MAR:   return {4'h0, mar_q};
            S_MDR:   return mdr_q;
            S_OE:    return {7'h0, bus_oe};
            S_RDY:   return {7'h0, prog_ready};
            S_DONE:  return {7'h0, prog_done};
            default: return {7'h0, cpu_hold};
        endcase
    endfunction

    // Monitor: mid-cycle, after inputs settle, check stamped status items and
    // every word the DUT presents on the bus.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] act;
        logic [7:0] w;
        #2;
        while (expq.size() > 0 && expq[0].cyc <= cyc_cnt) begin
            e   = expq.pop_front();
            act = sig_val(e.sig);
            total++;
            if (e.cyc != cyc_cnt || act !== e.val) begin
                bad++;
                $display("FAIL %s: got %h want %h (cycle %0d, due %0d)",
                         e.nm, act, e.val, cyc_cnt, e.cyc);
            end
        end
        if (bus_oe === 1'b1) begin
            total++;
            if (rdq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read: got bus_out %h with nothing expected (cycle %0d)",
                         bus_out, cyc_cnt);
            end else begin
                w = rdq.pop_front();
                if (bus_out !== w) begin
                    bad++;
                    $display("FAIL read_data: got %h want %h (cycle %0d)", bus_out, w, cyc_cnt);
                end
            end
        end
    end

    task automatic ex(input string nm, input int sig, input logic [7:0] v);
        exp_t t;
        t.cyc = cyc_cnt;
        t.sig = sig;
        t.val = v;
        t.nm  = nm;
        expq.push_back(t);
    endtask

    task automatic rd(input logic [7:0] v);
        rdq.push_back(v);
    endtask

    // Start a new cycle at negedge with every control at its idle level.
    task automatic nc();
        @(negedge clk);
        rst_n           = 1'b1;
        bus_in          = 8'h00;
        mar_addr_load_n = 1'b1;
        mdr_load_n      = 1'b1;
        ram_en_n        = 1'b1;
        ram_load_n      = 1'b1;
        prog_mode       = 1'b0;
        prog_valid      = 1'b0;
        prog_data       = 8'h00;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] pexp [5];
        pexp = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h14};

        rst_n = 1'b0; bus_in = 8'h00; mar_addr_load_n = 1'b1; mdr_load_n = 1'b1;
        ram_en_n = 1'b1; ram_load_n = 1'b1; prog_mode = 1'b0; prog_valid = 1'b0;
        prog_data = 8'h00;

        // Reset for two edges.
        nc(); rst_n = 1'b0;
        nc(); rst_n = 1'b0;
        nc();
        ex("rst_mar", S_MAR, 8'h00); ex("rst_mdr", S_MDR, 8'h00);
        ex("rst_oe", S_OE, 8'h00);   ex("rst_ready", S_RDY, 8'h00);
        ex("rst_done", S_DONE, 8'h00); ex("rst_hold", S_HOLD, 8'h00);

        // Full load 0x10..0x1F.
        nc(); prog_mode = 1'b1;
        ex("enter_hold", S_HOLD, 8'h00); ex("enter_ready", S_RDY, 8'h00);
        for (int k = 0; k < 16; k++) begin
            nc(); prog_mode = 1'b1; prog_valid = 1'b1; prog_data = 8'(8'h10 + k);
            ram_en_n = (k == 3) ? 1'b0 : 1'b1;
            ex("ld_ready", S_RDY, 8'h01); ex("ld_hold", S_HOLD, 8'h01);
            ex("ld_done", S_DONE, 8'h00);
            if (k == 3) ex("ld_oe_masked", S_OE, 8'h00);
        end
        nc(); prog_mode = 1'b1; prog_valid = 1'b1; prog_data = 8'hAA;
        ex("full_ready", S_RDY, 8'h00); ex("full_done", S_DONE, 8'h01);
        nc();
        ex("exit_hold_still", S_HOLD, 8'h01); ex("exit_done_still", S_DONE, 8'h01);
        nc();
        ex("run_hold", S_HOLD, 8'h00); ex("run_done", S_DONE, 8'h00);
        ex("held_mar", S_MAR, 8'h00); ex("held_mdr", S_MDR, 8'h00);

        // Reads of words 3, 15 and 0 (0xAA must not have wrapped to 0).
        nc(); bus_in = 8'h03; mar_addr_load_n = 1'b0;
        nc(); ram_en_n = 1'b0; ex("mar3", S_MAR, 8'h03); rd(8'h13);
        nc(); bus_in = 8'h0F; mar_addr_load_n = 1'b0;
        nc(); ram_en_n = 1'b0; rd(8'h1F);
        nc(); bus_in = 8'h00; mar_addr_load_n = 1'b0;
        nc(); ram_en_n = 1'b0; rd(8'h10);

        // Write 0x7E to word 5; read old word during the write cycle.
        nc(); bus_in = 8'h05; mar_addr_load_n = 1'b0;
        nc(); bus_in = 8'h7E; mdr_load_n = 1'b0; ex("mar5", S_MAR, 8'h05);
        nc(); ram_load_n = 1'b0; ram_en_n = 1'b0; ex("mdr7e", S_MDR, 8'h7E); rd(8'h15);
        nc(); ram_en_n = 1'b0; rd(8'h7E);

        // Write with same-cycle MAR load uses the old MAR: word 6 untouched.
        nc(); bus_in = 8'h06; mar_addr_load_n = 1'b0; ram_load_n = 1'b0;
        nc(); ram_en_n = 1'b0; ex("mar6", S_MAR, 8'h06); rd(8'h16);

        // Read and MAR load together: old address read, new address captured.
        nc(); bus_in = 8'h02; mar_addr_load_n = 1'b0; ram_en_n = 1'b0; rd(8'h16);
        nc(); ram_en_n = 1'b0; ex("mar2", S_MAR, 8'h02); rd(8'h12);

        // Partial load: 4 bytes, then prog_mode drops alongside a 5th byte.
        nc(); prog_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nc(); prog_mode = 1'b1; prog_valid = 1'b1; prog_data = 8'(8'hC0 + k);
        end
        nc(); prog_valid = 1'b1; prog_data = 8'hC4;
        ex("pdrop_hold", S_HOLD, 8'h01); ex("pdrop_ready", S_RDY, 8'h01);
        nc();
        ex("pdone_hold", S_HOLD, 8'h00); ex("pdone_ready", S_RDY, 8'h00);
        ex("pkeep_mar", S_MAR, 8'h02); ex("pkeep_mdr", S_MDR, 8'h7E);
        bus_in = 8'h00; mar_addr_load_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            nc(); ram_en_n = 1'b0;
            if (i < 5) begin
                mar_addr_load_n = 1'b0;
                bus_in = 8'(i);
            end
            rd(pexp[i-1]);
        end

        // Reset mid-stream after 2 bytes; the byte offered during reset is dropped.
        nc(); prog_mode = 1'b1;
        nc(); prog_mode = 1'b1; prog_valid = 1'b1; prog_data = 8'hD0;
        nc(); prog_mode = 1'b1; prog_valid = 1'b1; prog_data = 8'hD1;
        nc(); rst_n = 1'b0; prog_mode = 1'b1; prog_valid = 1'b1; prog_data = 8'hD2;
        ex("mrst_hold_before", S_HOLD, 8'h01);
        nc();
        ex("mrst_ready", S_RDY, 8'h00); ex("mrst_hold", S_HOLD, 8'h00);
        ex("mrst_mar", S_MAR, 8'h00); ex("mrst_mdr", S_MDR, 8'h00);
        ex("mrst_oe", S_OE, 8'h00);
        nc(); ram_en_n = 1'b0; mar_addr_load_n = 1'b0; bus_in = 8'h01; rd(8'hD0);
        nc(); ram_en_n = 1'b0; mar_addr_load_n = 1'b0; bus_in = 8'h02; rd(8'hD1);
        nc(); ram_en_n = 1'b0; rd(8'hC2);

        nc();
        nc();
        #4;
        total++;
        if (rdq.size() != 0 || expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d reads and %0d status items left, want 0 and 0",
                     rdq.size(), expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
